// File: rtl/cache_controller_nway.sv
// N-way set-associative cache controller with round-robin replacement,
// selectable write-back / write-through (both write-allocate) and global invalidate.
module cache_controller_nway #(
  parameter int ADDR_W      = 32,
  parameter int CACHE_BYTES = 8192,
  parameter int BLOCK_BYTES = 64,
  parameter int WAYS        = 2,
  parameter int WRITE_BACK  = 1,
  localparam int SETS = CACHE_BYTES / (BLOCK_BYTES * WAYS),
  localparam int OFF  = $clog2(BLOCK_BYTES),
  localparam int IDX  = $clog2(SETS),
  localparam int TAG  = ADDR_W - IDX - OFF,
  localparam int BLK  = BLOCK_BYTES * 8,
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              inv_all,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_hit,
  output logic [IDX-1:0]    cache_mem_index,
  output logic [WW-1:0]     cache_mem_way,
  output logic              cache_mem_write_en,
  output logic [BLK-1:0]    cache_mem_data_in,
  input  logic [BLK-1:0]    cache_mem_data_out,
  output logic [ADDR_W-1:0] main_mem_addr,
  output logic [BLK-1:0]    main_mem_wdata,
  output logic              main_mem_read_req,
  output logic              main_mem_write_req,
  input  logic [BLK-1:0]    main_mem_rdata,
  input  logic              main_mem_ready
);
  localparam logic [3:0] IDLE = 4'd0, LOOKUP = 4'd1, WB_REQ = 4'd2, WB_WAIT = 4'd3,
                         FILL_REQ = 4'd4, FILL_WAIT = 4'd5, REFILL = 4'd6,
                         WT_REQ = 4'd7, WT_WAIT = 4'd8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              wr;
  } req_t;

  logic [3:0]      state;
  req_t            req;
  logic            first_q, vptr_q;
  logic [WW-1:0]   victim_q;
  logic [BLK-1:0]  fill_q, wt_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [TAG-1:0]  tag_q   [SETS][WAYS];
  logic [WW-1:0]   ptr_q   [SETS];

  logic [TAG-1:0]  tag;
  logic [IDX-1:0]  idx;
  logic [OFF+2:0]  wbit;
  logic            hit, inv_found;
  logic [WW-1:0]   hit_way, inv_way, vsel;
  logic [BLK-1:0]  merged;

  assign tag  = req.addr[ADDR_W-1:IDX+OFF];
  assign idx  = req.addr[IDX+OFF-1:OFF];
  assign wbit = {req.addr[OFF-1:0], 3'b000} & ~((OFF+3)'(31));
  assign vsel = inv_found ? inv_way : ptr_q[idx];
  assign cpu_ready = (state == IDLE);

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1; hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1; inv_way = WW'(w);
      end
    end
  end

  always_comb begin
    merged = cache_mem_data_out;
    merged[wbit +: 32] = req.wdata;
  end

  always_comb begin
    cache_mem_index    = idx;
    cache_mem_way      = victim_q;
    cache_mem_write_en = 1'b0;
    cache_mem_data_in  = fill_q;
    main_mem_addr      = {tag, idx, {OFF{1'b0}}};
    main_mem_wdata     = wt_q;
    main_mem_read_req  = 1'b0;
    main_mem_write_req = 1'b0;
    case (state)
      LOOKUP: begin
        cache_mem_way = hit_way;
        if (hit && req.wr) begin
          cache_mem_write_en = 1'b1;
          cache_mem_data_in  = merged;
        end
      end
      WB_REQ: begin
        main_mem_write_req = 1'b1;
        main_mem_addr      = {tag_q[idx][victim_q], idx, {OFF{1'b0}}};
        main_mem_wdata     = cache_mem_data_out;
      end
      FILL_REQ: main_mem_read_req  = 1'b1;
      REFILL:   cache_mem_write_en = 1'b1;
      WT_REQ:   main_mem_write_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= '0;
      first_q  <= 1'b0;
      vptr_q   <= 1'b0;
      victim_q <= '0;
      fill_q   <= '0;
      wt_q     <= '0;
      cpu_done <= 1'b0;
      cpu_rdata <= '0;
      cpu_hit  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_read || cpu_write) begin
            req     <= '{addr: cpu_addr, wdata: cpu_wdata, wr: cpu_write};
            first_q <= 1'b1;
            state   <= LOOKUP;
          end else if (inv_all) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              dirty_q[s] <= '0;
            end
          end
        end
        LOOKUP: begin
          first_q <= 1'b0;
          if (first_q) cpu_hit <= hit;
          if (hit) begin
            if (!req.wr) begin
              cpu_rdata <= cache_mem_data_out[wbit +: 32];
              cpu_done  <= 1'b1;
              state     <= IDLE;
            end else if (WRITE_BACK != 0) begin
              dirty_q[idx][hit_way] <= 1'b1;
              cpu_done <= 1'b1;
              state    <= IDLE;
            end else begin
              wt_q  <= merged;
              state <= WT_REQ;
            end
          end else begin
            victim_q <= vsel;
            vptr_q   <= !inv_found;
            state    <= (WRITE_BACK != 0 && !inv_found && dirty_q[idx][vsel]) ? WB_REQ : FILL_REQ;
          end
        end
        WB_REQ:   state <= WB_WAIT;
        WB_WAIT:  if (main_mem_ready) state <= FILL_REQ;
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: begin
          if (main_mem_ready) begin
            fill_q <= main_mem_rdata;
            state  <= REFILL;
          end
        end
        REFILL: begin
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= 1'b0;
          tag_q[idx][victim_q]   <= tag;
          if (vptr_q) ptr_q[idx] <= (WAYS == 1) ? '0 : ptr_q[idx] + 1'b1;
          state <= LOOKUP;
        end
        WT_REQ:  state <= WT_WAIT;
        WT_WAIT: begin
          if (main_mem_ready) begin
            cpu_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench: instance 0 is 2-way write-back, instance 1 is 4-way write-through.
module tb_cache_controller_nway;
  logic        clk, rst_n;
  logic [31:0] cpu_addr [2], cpu_wdata [2], cpu_rdata [2];
  logic        cpu_read [2], cpu_write [2], inv_all [2];
  logic        cpu_ready [2], cpu_done [2], cpu_hit [2];
  logic [5:0]  cm_idx [2];
  logic [1:0]  cm_way [2];
  logic        cm_we [2];
  logic [511:0] cm_din [2], cm_dout [2];
  logic [31:0] mm_addr [2];
  logic [511:0] mm_wdata [2], mm_rdata [2];
  logic        mm_rd [2], mm_wr [2], mm_ready [2];
  logic        way0;
  logic [1:0]  way1;

  logic [511:0] darr [2][64][4];
  logic        rdy_q [2], stall [2], man_rdy [2];
  int          rd_cnt [2], wr_cnt [2];
  logic [31:0] rd_addr [2], wr_addr [2];
  logic [511:0] wr_data [2];

  int checks = 0, errors = 0;

  cache_controller_nway #(.WAYS(2), .WRITE_BACK(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_read(cpu_read[0]), .cpu_write(cpu_write[0]), .inv_all(inv_all[0]),
    .cpu_ready(cpu_ready[0]), .cpu_done(cpu_done[0]), .cpu_rdata(cpu_rdata[0]), .cpu_hit(cpu_hit[0]),
    .cache_mem_index(cm_idx[0]), .cache_mem_way(way0), .cache_mem_write_en(cm_we[0]),
    .cache_mem_data_in(cm_din[0]), .cache_mem_data_out(cm_dout[0]),
    .main_mem_addr(mm_addr[0]), .main_mem_wdata(mm_wdata[0]), .main_mem_read_req(mm_rd[0]),
    .main_mem_write_req(mm_wr[0]), .main_mem_rdata(mm_rdata[0]), .main_mem_ready(mm_ready[0]));

  cache_controller_nway #(.CACHE_BYTES(16384), .WAYS(4), .WRITE_BACK(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_read(cpu_read[1]), .cpu_write(cpu_write[1]), .inv_all(inv_all[1]),
    .cpu_ready(cpu_ready[1]), .cpu_done(cpu_done[1]), .cpu_rdata(cpu_rdata[1]), .cpu_hit(cpu_hit[1]),
    .cache_mem_index(cm_idx[1]), .cache_mem_way(way1), .cache_mem_write_en(cm_we[1]),
    .cache_mem_data_in(cm_din[1]), .cache_mem_data_out(cm_dout[1]),
    .main_mem_addr(mm_addr[1]), .main_mem_wdata(mm_wdata[1]), .main_mem_read_req(mm_rd[1]),
    .main_mem_write_req(mm_wr[1]), .main_mem_rdata(mm_rdata[1]), .main_mem_ready(mm_ready[1]));

  assign cm_way[0] = {1'b0, way0};
  assign cm_way[1] = way1;
  assign cm_dout[0] = darr[0][cm_idx[0]][cm_way[0]];
  assign cm_dout[1] = darr[1][cm_idx[1]][cm_way[1]];
  assign mm_ready[0] = rdy_q[0] | man_rdy[0];
  assign mm_ready[1] = rdy_q[1] | man_rdy[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory line for address a: word k = (a>>12)*0x100 + k.
  function automatic logic [511:0] line_of(input logic [31:0] a);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = ((a >> 12) << 8) + k;
    return l;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cm_we[i]) darr[i][cm_idx[i]][cm_way[i]] <= cm_din[i];
      rdy_q[i] <= (mm_rd[i] || mm_wr[i]) && !stall[i];
      if (mm_rd[i]) begin
        mm_rdata[i] <= line_of(mm_addr[i]);
        rd_cnt[i]   <= rd_cnt[i] + 1;
        rd_addr[i]  <= mm_addr[i];
      end
      if (mm_wr[i]) begin
        wr_cnt[i]  <= wr_cnt[i] + 1;
        wr_addr[i] <= mm_addr[i];
        wr_data[i] <= mm_wdata[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = cycles from the accepting edge to cpu_done.
  task automatic op(input int i, input logic [31:0] a, input logic [31:0] d,
                    input logic wr, input logic inv, output int lat);
    @(negedge clk);
    cpu_addr[i] = a; cpu_wdata[i] = d; cpu_read[i] = !wr; cpu_write[i] = wr; inv_all[i] = inv;
    @(negedge clk);
    cpu_read[i] = 1'b0; cpu_write[i] = 1'b0; inv_all[i] = 1'b0;
    lat = 1;
    while (!cpu_done[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_done[i]) chk("done_timeout", 32'(cpu_done[i]), 32'd1);
  endtask

  int lat, r0, w0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_addr[i] = '0; cpu_wdata[i] = '0; cpu_read[i] = 1'b0; cpu_write[i] = 1'b0;
      inv_all[i] = 1'b0; stall[i] = 1'b0; man_rdy[i] = 1'b0;
      rd_cnt[i] = 0; wr_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(cpu_ready[0]), 32'd1);
    chk("rst_done", 32'(cpu_done[0]), 32'd0);
    chk("rst_rdata", cpu_rdata[0], 32'd0);
    chk("rst_hit", 32'(cpu_hit[0]), 32'd0);
    chk("rst_strobes", {29'd0, mm_rd[0], mm_wr[0], cm_we[0]}, 32'd0);

    // ---- write-back 2-way ----
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    op(0, 32'h1040, 0, 1'b0, 1'b0, lat);
    chk("miss_lat", lat, 6);
    chk("miss_rdata", cpu_rdata[0], 32'h100);
    chk("miss_hit", 32'(cpu_hit[0]), 32'd0);
    chk("miss_rdcnt", rd_cnt[0] - r0, 1);
    chk("miss_rdaddr", rd_addr[0], 32'h1040);
    chk("miss_wrcnt", wr_cnt[0] - w0, 0);

    r0 = rd_cnt[0];
    op(0, 32'h1048, 0, 1'b0, 1'b0, lat);
    chk("hit_lat", lat, 2);
    chk("hit_rdata", cpu_rdata[0], 32'h102);
    chk("hit_hit", 32'(cpu_hit[0]), 32'd1);
    chk("hit_rdcnt", rd_cnt[0] - r0, 0);

    w0 = wr_cnt[0];
    op(0, 32'h1040, 32'hDEADBEEF, 1'b1, 1'b0, lat);
    chk("wbhit_lat", lat, 2);
    chk("wbhit_wrcnt", wr_cnt[0] - w0, 0);
    op(0, 32'h3040, 0, 1'b0, 1'b0, lat);
    chk("fill2_lat", lat, 6);
    chk("fill2_rdata", cpu_rdata[0], 32'h300);

    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    op(0, 32'h5040, 0, 1'b0, 1'b0, lat);
    chk("evict_lat", lat, 8);
    chk("evict_wrcnt", wr_cnt[0] - w0, 1);
    chk("evict_wraddr", wr_addr[0], 32'h1040);
    chk("evict_wrword0", wr_data[0][31:0], 32'hDEADBEEF);
    chk("evict_rdaddr", rd_addr[0], 32'h5040);
    chk("evict_rdcnt", rd_cnt[0] - r0, 1);
    chk("evict_rdata", cpu_rdata[0], 32'h500);
    op(0, 32'h3040, 0, 1'b0, 1'b0, lat);
    chk("way1_kept", 32'(cpu_hit[0]), 32'd1);

    // dirty line then invalidate: dirty data is discarded
    op(0, 32'h5044, 32'h11112222, 1'b1, 1'b0, lat);
    chk("dirty_hit", 32'(cpu_hit[0]), 32'd1);
    @(negedge clk); inv_all[0] = 1'b1;
    @(negedge clk); inv_all[0] = 1'b0;
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    op(0, 32'h5044, 0, 1'b0, 1'b0, lat);
    chk("inv_hit", 32'(cpu_hit[0]), 32'd0);
    chk("inv_lat", lat, 6);
    chk("inv_wrcnt", wr_cnt[0] - w0, 0);
    chk("inv_rdcnt", rd_cnt[0] - r0, 1);
    chk("inv_rdata", cpu_rdata[0], 32'h501);

    // invalidate alongside a request is ignored
    op(0, 32'h5048, 0, 1'b0, 1'b1, lat);
    chk("invreq_lat", lat, 2);
    chk("invreq_rdata", cpu_rdata[0], 32'h502);
    op(0, 32'h5044, 0, 1'b0, 1'b0, lat);
    chk("invreq_kept", 32'(cpu_hit[0]), 32'd1);

    // ---- write-through 4-way ----
    for (int t = 1; t <= 4; t++) begin
      op(1, 32'(t) << 12, 0, 1'b0, 1'b0, lat);
      chk("rr_fill_lat", lat, 6);
    end
    op(1, 32'h5000, 0, 1'b0, 1'b0, lat);
    chk("rr5_rdata", cpu_rdata[1], 32'h500);
    op(1, 32'h6000, 0, 1'b0, 1'b0, lat);
    chk("rr_way0", darr[1][0][0][31:0], 32'h500);
    chk("rr_way1", darr[1][0][1][31:0], 32'h600);
    chk("rr_way2", darr[1][0][2][31:0], 32'h300);
    chk("rr_way3", darr[1][0][3][31:0], 32'h400);
    op(1, 32'h3000, 0, 1'b0, 1'b0, lat);
    chk("rr_hit3", 32'(cpu_hit[1]), 32'd1);
    chk("rr_hit3_lat", lat, 2);

    op(1, 32'h1040, 0, 1'b0, 1'b0, lat);
    w0 = wr_cnt[1];
    op(1, 32'h1044, 32'hCAFEF00D, 1'b1, 1'b0, lat);
    chk("wt_lat", lat, 4);
    chk("wt_hit", 32'(cpu_hit[1]), 32'd1);
    chk("wt_wrcnt", wr_cnt[1] - w0, 1);
    chk("wt_wraddr", wr_addr[1], 32'h1040);
    chk("wt_word1", wr_data[1][63:32], 32'hCAFEF00D);
    chk("wt_word0", wr_data[1][31:0], 32'h100);
    chk("wt_array", darr[1][1][0][63:32], 32'hCAFEF00D);
    op(1, 32'h1044, 0, 1'b0, 1'b0, lat);
    chk("wt_readback", cpu_rdata[1], 32'hCAFEF00D);

    w0 = wr_cnt[1];
    for (int t = 2; t <= 5; t++) op(1, (32'(t) << 12) | 32'h40, 0, 1'b0, 1'b0, lat);
    chk("wt_evict_lat", lat, 6);
    chk("wt_evict_wrcnt", wr_cnt[1] - w0, 0);
    chk("wt_evict_rdaddr", rd_addr[1], 32'h5040);

    // ---- reset during FILL_WAIT ----
    stall[0] = 1'b1;
    @(negedge clk); cpu_addr[0] = 32'h7040; cpu_read[0] = 1'b1;
    @(negedge clk); cpu_read[0] = 1'b0;
    @(negedge clk);
    chk("mid_fillreq", 32'(mm_rd[0]), 32'd1);
    @(negedge clk);
    chk("mid_busy", 32'(cpu_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(cpu_ready[0]), 32'd1);
    chk("mid_rst_rdata", cpu_rdata[0], 32'd0);
    chk("mid_rst_hit", 32'(cpu_hit[0]), 32'd0);
    chk("mid_rst_strobes", {29'd0, mm_rd[0], mm_wr[0], cm_we[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1; stall[0] = 1'b0;
    @(negedge clk); man_rdy[0] = 1'b1;
    @(negedge clk); man_rdy[0] = 1'b0;
    @(negedge clk);
    chk("stray_ready_done", 32'(cpu_done[0]), 32'd0);
    chk("stray_ready_idle", 32'(cpu_ready[0]), 32'd1);
    op(0, 32'h5044, 0, 1'b0, 1'b0, lat);
    chk("post_rst_hit", 32'(cpu_hit[0]), 32'd0);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_rdata", cpu_rdata[0], 32'h501);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
